// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the non-restoring integer square root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  // Number of CALC cycles: H root bits, STEPS of them per cycle.
  function automatic int sqrt_iters(int width, int steps);
    return (width / 2) / steps;
  endfunction

  // Legal parameter combinations: even width in 4..64, STEPS dividing WIDTH/2.
  function automatic bit sqrt_width_ok(int width, int steps);
    return (width % 2 == 0) && (width >= 4) && (width <= 64) &&
           (steps >= 1) && ((width / 2) % steps == 0);
  endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// One non-restoring square-root iteration: consumes two radicand bits, yields one root bit.
module sqrt_nr_step #(
  parameter int H = 16
) (
  input  logic [H-1:0] q,
  input  logic [H+1:0] r,
  input  logic [1:0]   d,
  output logic [H-1:0] q_nxt,
  output logic [H+1:0] r_nxt
);

  logic [H+1:0] r_sh;

  // The top bits of r<<2 may wrap; the true r' always fits in H+2 bits, so modular math is exact.
  assign r_sh  = (r << 2) | {{H{1'b0}}, d};
  assign r_nxt = r[H+1] ? (r_sh + {q, 2'b11}) : (r_sh - {q, 2'b01});
  assign q_nxt = {q[H-2:0], ~r_nxt[H+1]};

endmodule

// File: rtl/integer_sqrt_nr.sv
// Handshaked multi-cycle integer square root: root = floor(sqrt(x)), rem = x - root^2.
module integer_sqrt_nr
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int H  = WIDTH / 2;
  localparam int N  = sqrt_iters(WIDTH, STEPS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (!sqrt_width_ok(WIDTH, STEPS)) begin : g_bad_params
    $error("integer_sqrt_nr: WIDTH must be even in 4..64 and STEPS must divide WIDTH/2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op;
  logic [H-1:0]     q;
  logic [H+1:0]     r;
  logic [CW-1:0]    cnt;
  logic [H-1:0]     root_q;
  logic [H:0]       rem_q;
  logic             out_valid_q;

  logic [STEPS:0][H-1:0] qc;
  logic [STEPS:0][H+1:0] rc;
  logic [H+1:0]          r_fix;

  assign qc[0] = q;
  assign rc[0] = r;

  for (genvar j = 0; j < STEPS; j++) begin : g_step
    sqrt_nr_step #(.H(H)) u_step (
      .q    (qc[j]),
      .r    (rc[j]),
      .d    (op[WIDTH-1-2*j -: 2]),
      .q_nxt(qc[j+1]),
      .r_nxt(rc[j+1])
    );
  end

  // A negative final remainder is restored by adding back 2q+1.
  assign r_fix = r[H+1] ? (r + {1'b0, q, 1'b1}) : r;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign root      = root_q;
  assign rem       = rem_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)       state_d = CALC;
      CALC:    if (cnt == '0)      state_d = FIX;
      FIX:                         state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: capture operand, run STEPS iterations per CALC cycle, correct and publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      q           <= '0;
      r           <= '0;
      cnt         <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      root_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op  <= in_data;
          q   <= '0;
          r   <= '0;
          cnt <= CNT_LAST;
        end
        CALC: begin
          op <= op << (2 * STEPS);
          q  <= qc[STEPS];
          r  <= rc[STEPS];
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          r           <= r_fix;
          root_q      <= q;
          rem_q       <= r_fix[H:0];
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_integer_sqrt_nr.sv
// Directed and regression bench for integer_sqrt_nr.
module tb_integer_sqrt_nr;

  logic clk, rst;
  int   pass_cnt, total_cnt;

  // WIDTH=32, STEPS=1 instance
  logic        iv1, rdy1, ov1, ordy1, fl1;
  logic [31:0] id1;
  logic [15:0] rt1;
  logic [16:0] rm1;

  // WIDTH=32, STEPS=4 instance
  logic        iv4, rdy4, ov4, ordy4, fl4;
  logic [31:0] id4;
  logic [15:0] rt4;
  logic [16:0] rm4;

  bit reg_go;
  int reg_done;
  localparam int OPS = 2500;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  integer_sqrt_nr #(.WIDTH(32), .STEPS(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .root(rt1), .rem(rm1));

  integer_sqrt_nr #(.WIDTH(32), .STEPS(4)) u_s4 (
    .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(rdy4), .in_data(id4),
    .out_valid(ov4), .out_ready(ordy4), .root(rt4), .rem(rm4));

  // Regression instances, widths 8/16/32/64, all with 4 CALC cycles.
  for (genvar g = 0; g < 4; g++) begin : rg
    localparam int W = 8 << g;
    localparam int S = 1 << g;
    logic           iv, rdy, ov;
    logic [W-1:0]   x;
    logic [W/2-1:0] rt;
    logic [W/2:0]   rm;

    integer_sqrt_nr #(.WIDTH(W), .STEPS(S)) u (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv), .in_ready(rdy), .in_data(x),
      .out_valid(ov), .out_ready(1'b1), .root(rt), .rem(rm));

    initial begin : drv
      logic [63:0]  rnd;
      logic [127:0] xx, r1;
      int           w, lat;
      bit           ok;
      iv = 1'b0;
      x  = '0;
      wait (reg_go);
      for (int i = 0; i < OPS; i++) begin
        rnd = {$urandom, $urandom};
        w = 0;
        while (!rdy && w < 50) begin @(posedge clk); #1; w++; end
        x  = (i == 0) ? '1 : (i == 1) ? '0 : (i == 2) ? W'(1) : rnd[W-1:0];
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ov && lat < 50);
        xx = 128'(x);
        r1 = 128'(rt);
        ok = ov && (lat == 5) && (r1 * r1 <= xx) && ((r1 + 1) * (r1 + 1) > xx) &&
             (128'(rm) == xx - r1 * r1);
        total_cnt++;
        if (!ok) $display("FAIL regress_w%0d x=%0h root=%0d rem=%0d lat=%0d (need root^2<=x<(root+1)^2, rem=x-root^2, lat 5)",
                          W, x, rt, rm, lat);
        else pass_cnt++;
      end
      reg_done++;
    end
  end

  // Issue one operand on the selected 32-bit instance and wait for its result.
  task automatic op32(input bit s4, input logic [31:0] xv,
                      output logic [15:0] rt, output logic [16:0] rm, output int lat);
    int w;
    w = 0;
    while (!(s4 ? rdy4 : rdy1) && w < 100) begin @(posedge clk); #1; w++; end
    if (s4) begin iv4 = 1'b1; id4 = xv; end
    else    begin iv1 = 1'b1; id1 = xv; end
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    id1 = '1;   id4 = '1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(s4 ? ov4 : ov1) && lat < 100);
    if (!(s4 ? ov4 : ov1)) lat = -1;
    rt = s4 ? rt4 : rt1;
    rm = s4 ? rm4 : rm1;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if (ov1 !== 1'b0 || rt1 !== 16'd0 || rm1 !== 17'd0 || ov4 !== 1'b0 || rt4 !== 16'd0)
      $display("FAIL reset_outputs ov=%b root=%0d rem=%0d ov4=%b root4=%0d expected all 0", ov1, rt1, rm1, ov4, rt4);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (rdy1 !== 1'b1 || rdy4 !== 1'b1)
      $display("FAIL reset_in_ready got %b/%b expected 1/1", rdy1, rdy4);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] xs [5] = '{32'd0, 32'd1, 32'd99, 32'd1000000, 32'hFFFFFFFF};
    logic [15:0] er [5] = '{16'd0, 16'd1, 16'd9, 16'd1000, 16'd65535};
    logic [16:0] em [5] = '{17'd0, 17'd0, 17'd18, 17'd0, 17'd131070};
    logic [15:0] rt;
    logic [16:0] rm;
    int lat;
    for (int i = 0; i < 5; i++) begin
      op32(1'b0, xs[i], rt, rm, lat);
      total_cnt++;
      if (rt !== er[i] || rm !== em[i] || lat != 17)
        $display("FAIL basic_s1 x=%0d root=%0d rem=%0d lat=%0d expected %0d %0d 17", xs[i], rt, rm, lat, er[i], em[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_steps4();
    logic [31:0] xs [3] = '{32'h12345678, 32'hDEADBEEF, 32'hFFFFFFFF};
    logic [15:0] er [3] = '{16'd17476, 16'd61122, 16'd65535};
    logic [16:0] em [3] = '{17'd9320, 17'd29675, 17'd131070};
    logic [15:0] rt;
    logic [16:0] rm;
    int lat;
    for (int i = 0; i < 3; i++) begin
      op32(1'b1, xs[i], rt, rm, lat);
      total_cnt++;
      if (rt !== er[i] || rm !== em[i] || lat != 5)
        $display("FAIL steps4 x=%0h root=%0d rem=%0d lat=%0d expected %0d %0d 5", xs[i], rt, rm, lat, er[i], em[i]);
      else pass_cnt++;
      op32(1'b0, xs[i], rt, rm, lat);
      total_cnt++;
      if (rt !== er[i] || rm !== em[i] || lat != 17)
        $display("FAIL steps1_same x=%0h root=%0d rem=%0d lat=%0d expected %0d %0d 17", xs[i], rt, rm, lat, er[i], em[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int w, t0;
    // Accept-to-accept spacing with out_ready high is N+3 = 19 cycles.
    w = 0;
    while (!rdy1 && w < 50) begin @(posedge clk); #1; w++; end
    iv1 = 1'b1; id1 = 32'd7;
    @(posedge clk); #1;
    t0 = 0;
    while (!rdy1 && t0 < 100) begin @(posedge clk); #1; t0++; end
    @(posedge clk); #1;
    t0++;
    iv1 = 1'b0;
    total_cnt++;
    if (t0 != 19 || rt1 !== 16'd2 || rm1 !== 17'd3)
      $display("FAIL back_to_back spacing=%0d root=%0d rem=%0d expected 19 2 3", t0, rt1, rm1);
    else pass_cnt++;
    w = 0;
    while (!ov1 && w < 50) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (ov1 !== 1'b1 || rt1 !== 16'd2 || rm1 !== 17'd3)
      $display("FAIL back_to_back_second ov=%b root=%0d rem=%0d expected 1 2 3", ov1, rt1, rm1);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int w, lat;
    w = 0;
    while (!rdy1 && w < 50) begin @(posedge clk); #1; w++; end
    ordy1 = 1'b0;
    iv1 = 1'b1; id1 = 32'd144;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 100) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if (lat != 17) $display("FAIL bp_latency got %0d expected 17", lat);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      total_cnt++;
      if (ov1 !== 1'b1 || rt1 !== 16'd12 || rm1 !== 17'd0 || rdy1 !== 1'b0)
        $display("FAIL bp_hold cycle=%0d ov=%b root=%0d rem=%0d in_ready=%b expected 1 12 0 0", c, ov1, rt1, rm1, rdy1);
      else pass_cnt++;
      if (c < 5) begin @(posedge clk); #1; end
    end
    ordy1 = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (rdy1 !== 1'b1 || ov1 !== 1'b0)
      $display("FAIL bp_release in_ready=%b ov=%b expected 1 0", rdy1, ov1);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [15:0] rt;
    logic [16:0] rm;
    int w, lat;
    bit seen;
    w = 0;
    while (!rdy1 && w < 50) begin @(posedge clk); #1; w++; end
    iv1 = 1'b1; id1 = 32'd50;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fl1 = 1'b1;
    @(posedge clk); #1;
    fl1 = 1'b0;
    total_cnt++;
    if (rdy1 !== 1'b1 || ov1 !== 1'b0 || rt1 !== 16'd0 || rm1 !== 17'd0)
      $display("FAIL flush_idle in_ready=%b ov=%b root=%0d rem=%0d expected 1 0 0 0", rdy1, ov1, rt1, rm1);
    else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (ov1) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL flush_no_result out_valid asserted after flush, expected never");
    else pass_cnt++;
    fl1 = 1'b1; iv1 = 1'b1; id1 = 32'd9;
    @(posedge clk); #1;
    fl1 = 1'b0; iv1 = 1'b0;
    total_cnt++;
    if (rdy1 !== 1'b1) $display("FAIL flush_blocks_accept in_ready=%b expected 1", rdy1);
    else pass_cnt++;
    op32(1'b0, 32'd50, rt, rm, lat);
    total_cnt++;
    if (rt !== 16'd7 || rm !== 17'd1 || lat != 17)
      $display("FAIL flush_after root=%0d rem=%0d lat=%0d expected 7 1 17", rt, rm, lat);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [15:0] rt;
    logic [16:0] rm;
    int w, lat;
    w = 0;
    while (!rdy1 && w < 50) begin @(posedge clk); #1; w++; end
    iv1 = 1'b1; id1 = 32'd99;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ov1 !== 1'b0 || rt1 !== 16'd0 || rm1 !== 17'd0 || rdy1 !== 1'b1)
      $display("FAIL async_reset ov=%b root=%0d rem=%0d in_ready=%b expected 0 0 0 1", ov1, rt1, rm1, rdy1);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    op32(1'b0, 32'd2, rt, rm, lat);
    total_cnt++;
    if (rt !== 16'd1 || rm !== 17'd1 || lat != 17)
      $display("FAIL reset_after root=%0d rem=%0d lat=%0d expected 1 1 17", rt, rm, lat);
    else pass_cnt++;
  endtask

  task automatic test_regression();
    int cyc;
    reg_go = 1'b1;
    cyc = 0;
    while (reg_done < 4 && cyc < 60000) begin @(posedge clk); cyc++; end
    total_cnt++;
    if (reg_done != 4) $display("FAIL regress_timeout done=%0d expected 4", reg_done);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; reg_done = 0; reg_go = 1'b0;
    rst = 1'b1;
    iv1 = 1'b0; id1 = '0; ordy1 = 1'b1; fl1 = 1'b0;
    iv4 = 1'b0; id4 = '0; ordy4 = 1'b1; fl4 = 1'b0;
    test_reset();
    test_basic();
    test_steps4();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_regression();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/integer_sqrt_nr.md
# integer_sqrt_nr

Parametrised, handshaked integer square-root unit using the non-restoring digit recurrence. It computes root = floor(sqrt(x)) and rem = x − root² for an unsigned WIDTH-bit operand, retiring STEPS root bits per clock. It sits behind the datapath issue stage as a multi-cycle functional unit. Valid/ready on both sides and a synchronous flush let the pipeline stall or kill an operation in flight.

## Interface
- WIDTH, 32: operand width; even, 4..64.
- STEPS, 1: root bits resolved per cycle; must divide WIDTH/2 (1, 2, 4, …).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort; highest priority after rst.
- in_valid  in  1  operand offered.
- in_ready  out  1  unit idle and able to accept.
- in_data  in  WIDTH  unsigned radicand.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- root  out  WIDTH/2  floor(sqrt(in_data)).
- rem  out  WIDTH/2+1  in_data − root², always ≤ 2·root.

## Operation
- Constants: H = WIDTH/2; N = H/STEPS, the number of CALC cycles.
- Internal registers:
  - op: the captured operand, shifted left 2 bits per iteration.
  - q: the H-bit partial root.
  - r: the signed (H+2)-bit partial remainder.
  - cnt: counts N−1 down to 0.
- The operand is captured at accept; later in_data changes are ignored.
- State IDLE:
  - in_ready=1.
  - When in_valid, accept: op←in_data, q←0, r←0, cnt←N−1, go to CALC.
- State CALC: STEPS chained iterations per cycle. Each iteration:
  - d = next 2 MSBs of op.
  - If r≥0: r' = (r<<2 | d) − (q<<2 | 1); otherwise r' = (r<<2 | d) + (q<<2 | 3).
  - q' = q<<1 | (r'≥0).
  - After the last cycle's iterations (cnt=0), go to FIX; otherwise cnt−1.
- State FIX: one correction cycle.
  - If r<0: r ← r + (q<<1 | 1).
  - root←q, rem←r[H:0], out_valid←1, go to DONE.
- State DONE:
  - out_valid=1; root and rem are held stable.
  - On out_valid && out_ready: out_valid←0, go to IDLE.
  - No new operand is accepted in the same cycle; in_ready rises the following cycle.
- Arithmetic:
  - All r arithmetic is H+2 bits two's complement, with no overflow for any WIDTH-bit input.
  - rem is non-negative after FIX.
- flush:
  - Any state goes to IDLE; out_valid←0; root and rem clear to 0.
  - flush with in_valid in the same cycle: the operand is not accepted.
- Reset:
  - Asynchronous; state=IDLE, out_valid=0, root=0, rem=0, cnt=0, q=0, r=0.
  - in_ready is 1 once rst deasserts.
  - Reset mid-operation discards the operation with no partial output.

## Timing
- Accept on edge k: CALC runs on edges k+1..k+N, FIX on edge k+N+1.
- out_valid is visible from edge k+N+1; latency is N+1 cycles from accept.
- For WIDTH=32: STEPS=1 gives latency 17; STEPS=4 gives latency 5.
- Throughput: one operation per N+3 cycles with out_ready tied high.
- Backpressure: DONE holds indefinitely and root/rem do not change while out_ready=0.
- in_ready is registered-state-derived; no combinational path from out_ready to in_ready.
- Critical path: STEPS chained add/sub stages of H+2 bits.

## Structure
- Package sqrt_pkg:
  - state enum: IDLE, CALC, FIX, DONE.
  - localparam function sqrt_iters(WIDTH, STEPS) returning N.
  - width-check function used by an elaboration-time assertion: WIDTH even, H mod STEPS = 0.
- Sub-module sqrt_nr_step:
  - Combinational single iteration, (q, r, d) → (q', r'), parametrised on H.
  - Instantiated STEPS times in a generate chain.

## Test plan
- WIDTH=32, STEPS=1, out_ready=1. Required results:
  - 0 → root 0, rem 0.
  - 1 → root 1, rem 0.
  - 99 → root 9, rem 18.
  - 1000000 → root 1000, rem 0.
  - 0xFFFFFFFF → root 65535, rem 131070.
  - Every case has out_valid exactly 17 cycles after accept.
- WIDTH=32, STEPS=4: 2 random operands plus 0xFFFFFFFF.
  - Results match the STEPS=1 results.
  - Latency is 5 cycles.
- Backpressure: input 144 with out_ready low for 6 cycles after out_valid.
  - root=12 and rem=0 stay stable; in_ready=0 throughout.
  - in_ready=1 the cycle after out_ready rises.
- flush on the 3rd CALC cycle of input 50.
  - Next cycle: IDLE, in_ready=1, out_valid never asserts.
  - A following input of 50 gives root 7, rem 1.
- rst pulsed asynchronously mid-CALC: outputs are 0 immediately; after release, input 2 gives root 1, rem 1.
- Random regression, 10k operands, WIDTH ∈ {8, 16, 32, 64}: root² ≤ x < (root+1)² and rem = x − root².
